// File: rtl/ifetch_bq.sv
// ============================================================================
// Module   : ifetch_bq
// Purpose  : Fetch unit with sequential PC generation, icache handshake, a
//            2-bit branch predictor and a decoupling issue queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifetch_bq #(
  parameter int          IQ_DEPTH  = 8,
  parameter int          BHT_IDX_W = 7,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_inst,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [31:0] iss_pc,
  output logic [31:0] iss_inst,
  output logic        iss_pred_taken,
  output logic [31:0] iss_pred_pc,
  input  logic        jalr_done,
  input  logic [31:0] jalr_target,
  input  logic        bp_upd_valid,
  input  logic [31:0] bp_upd_pc,
  input  logic        bp_upd_taken,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int                 c_PTR_W    = $clog2(IQ_DEPTH);
  localparam int                 c_BHT_SIZE = 1 << BHT_IDX_W;
  localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W+1)'(IQ_DEPTH);
  localparam logic [6:0]         c_OP_JAL   = 7'b1101111;
  localparam logic [6:0]         c_OP_BR    = 7'b1100011;
  localparam logic [6:0]         c_OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_JALR = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [31:0]          r_fetch_pc, w_fetch_pc_nxt;
  logic                 r_req_valid;
  logic [31:0]          r_req_addr;
  logic                 w_req_fire, w_push, w_pop;

  logic [1:0]           r_bht [c_BHT_SIZE];
  logic [31:0]          r_q_pc      [IQ_DEPTH];
  logic [31:0]          r_q_inst    [IQ_DEPTH];
  logic [31:0]          r_q_pred_pc [IQ_DEPTH];
  logic                 r_q_taken   [IQ_DEPTH];
  logic [c_PTR_W-1:0]   r_head, r_tail;
  logic [c_PTR_W:0]     r_count;

  logic [6:0]           w_opcode;
  logic [31:0]          w_j_imm, w_b_imm, w_pred_pc;
  logic                 w_pred_taken, w_is_jalr;
  logic [BHT_IDX_W-1:0] w_bht_idx, w_upd_idx;
  logic                 w_unused_upd;

  assign w_opcode  = ic_resp_inst[6:0];
  assign w_j_imm   = {{12{ic_resp_inst[31]}}, ic_resp_inst[19:12], ic_resp_inst[20],
                      ic_resp_inst[30:21], 1'b0};
  assign w_b_imm   = {{20{ic_resp_inst[31]}}, ic_resp_inst[7], ic_resp_inst[30:25],
                      ic_resp_inst[11:8], 1'b0};
  assign w_bht_idx = r_fetch_pc[BHT_IDX_W+1:2];
  assign w_upd_idx = bp_upd_pc[BHT_IDX_W+1:2];
  assign w_unused_upd = ^{bp_upd_pc[31:BHT_IDX_W+2], bp_upd_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not visible
  always_comb begin
    w_pred_taken = 1'b0;
    w_pred_pc    = r_fetch_pc + 32'd4;
    w_is_jalr    = 1'b0;
    case (w_opcode)
      c_OP_JAL: begin
        w_pred_taken = 1'b1;
        w_pred_pc    = r_fetch_pc + w_j_imm;
      end
      c_OP_BR: begin
        if (r_bht[w_bht_idx][1]) begin
          w_pred_taken = 1'b1;
          w_pred_pc    = r_fetch_pc + w_b_imm;
        end
      end
      c_OP_JALR: w_is_jalr = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_fire     = 1'b0;
    w_push         = 1'b0;
    if (redirect) begin
      w_fetch_pc_nxt = redirect_pc;
      // An outstanding request whose response has not arrived must be swallowed
      w_state_nxt    = (r_state == S_WAIT && !ic_resp_valid) ? S_DROP : S_REQ;
    end else begin
      case (r_state)
        S_REQ: begin
          if (r_count < c_DEPTH) begin
            w_req_fire  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ic_resp_valid) begin
            w_push = 1'b1;
            if (w_is_jalr) begin
              w_state_nxt = S_JALR;
            end else begin
              w_fetch_pc_nxt = w_pred_pc;
              w_state_nxt    = S_REQ;
            end
          end
        end
        S_JALR: begin
          if (jalr_done) begin
            w_fetch_pc_nxt = jalr_target;
            w_state_nxt    = S_REQ;
          end
        end
        S_DROP: begin
          if (ic_resp_valid) w_state_nxt = S_REQ;
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  assign w_pop = (r_count != '0) && iss_ready && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_fetch_pc  <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_addr  <= RESET_PC;
    end else if (rdy) begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_req_valid <= w_req_fire;
      if (w_req_fire) r_req_addr <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (redirect) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && w_push) begin
      r_q_pc[r_tail]      <= r_fetch_pc;
      r_q_inst[r_tail]    <= ic_resp_inst;
      r_q_taken[r_tail]   <= w_pred_taken;
      r_q_pred_pc[r_tail] <= w_pred_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_BHT_SIZE; i++) r_bht[i] <= 2'b01;
    end else if (rdy && bp_upd_valid) begin
      if (bp_upd_taken) begin
        if (r_bht[w_upd_idx] != 2'b11) r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
      end else begin
        if (r_bht[w_upd_idx] != 2'b00) r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
      end
    end
  end

  assign ic_req_valid   = r_req_valid & rdy;
  assign ic_req_addr    = r_req_addr;
  assign iss_valid      = (r_count != '0);
  assign iss_pc         = iss_valid ? r_q_pc[r_head]      : 32'h0;
  assign iss_inst       = iss_valid ? r_q_inst[r_head]    : 32'h0;
  assign iss_pred_taken = iss_valid ? r_q_taken[r_head]   : 1'b0;
  assign iss_pred_pc    = iss_valid ? r_q_pred_pc[r_head] : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_bq.sv
// ============================================================================
// Module   : tb_ifetch_bq
// Purpose  : Directed, table-driven bench for the ifetch_bq fetch unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_bq;

  localparam logic [31:0] c_ADDI   = 32'h00000013;
  localparam logic [31:0] c_BEQ20  = 32'h02000063;
  localparam logic [31:0] c_JAL_M4 = 32'hFFDFF06F;
  localparam logic [31:0] c_JAL_M8 = 32'hFF9FF06F;
  localparam logic [31:0] c_JAL_M16 = 32'hFF1FF06F;
  localparam logic [31:0] c_JAL_M32 = 32'hFE1FF06F;
  localparam logic [31:0] c_JALR   = 32'h00008067;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic        ic_req_valid, ic_resp_valid = 1'b0;
  logic [31:0] ic_req_addr, ic_resp_inst = 32'h0;
  logic        iss_valid, iss_ready = 1'b0, iss_pred_taken;
  logic [31:0] iss_pc, iss_inst, iss_pred_pc;
  logic        jalr_done = 1'b0, bp_upd_valid = 1'b0, bp_upd_taken = 1'b0, redirect = 1'b0;
  logic [31:0] jalr_target = 32'h0, bp_upd_pc = 32'h0, redirect_pc = 32'h0;

  int total = 0;
  int bad   = 0;

  ifetch_bq #(.IQ_DEPTH(8), .BHT_IDX_W(7), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pc(iss_pc), .iss_inst(iss_inst),
    .iss_pred_taken(iss_pred_taken), .iss_pred_pc(iss_pred_pc),
    .jalr_done(jalr_done), .jalr_target(jalr_target),
    .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    int          n_upd;
    logic        upd_taken;
    logic        exp_taken;
    logic [31:0] exp_pred_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ic_req_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s: no request seen, expected addr %h", name, exp_addr);
    end else begin
      check(name, ic_req_addr, exp_addr);
    end
  endtask

  task automatic respond(input logic [31:0] inst);
    ic_resp_inst  = inst;
    ic_resp_valid = 1'b1;
    @(negedge clk);
    ic_resp_valid = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [31:0] pc, input logic [31:0] inst,
                            input logic taken, input logic [31:0] ppc);
    check({name, "_pc"}, {iss_valid, iss_pc[30:0]}, {1'b1, pc[30:0]});
    check({name, "_inst"}, iss_inst, inst);
    check({name, "_pred"}, {31'h0, iss_pred_taken}, {31'h0, taken});
    check({name, "_ppc"}, iss_pred_pc, ppc);
  endtask

  task automatic expect_idle(input int cycles, input string name);
    bit any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ic_req_valid) any = 1'b1;
    end
    check(name, {31'h0, any}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h10, c_BEQ20,   0, 1'b0, 1'b0, 32'h14};
    vecs[1] = '{32'h14, c_JAL_M4,  2, 1'b1, 1'b1, 32'h10};
    vecs[2] = '{32'h10, c_BEQ20,   0, 1'b0, 1'b1, 32'h30};
    vecs[3] = '{32'h30, c_JAL_M32, 1, 1'b1, 1'b1, 32'h10};
    vecs[4] = '{32'h10, c_BEQ20,   1, 1'b0, 1'b1, 32'h30};
    vecs[5] = '{32'h30, c_JAL_M32, 0, 1'b0, 1'b1, 32'h10};
    vecs[6] = '{32'h10, c_BEQ20,   2, 1'b0, 1'b0, 32'h14};
    vecs[7] = '{32'h14, c_JAL_M4,  1, 1'b0, 1'b1, 32'h10};
    vecs[8] = '{32'h10, c_BEQ20,   2, 1'b1, 1'b1, 32'h30};
    vecs[9] = '{32'h30, c_ADDI,    0, 1'b0, 1'b0, 32'h34};

    repeat (3) @(negedge clk);
    check("rst_req_valid", {31'h0, ic_req_valid}, 32'h0);
    check("rst_req_addr", ic_req_addr, 32'h0);
    check("rst_iss", {iss_valid, iss_pred_taken, 30'h0} | iss_pc | iss_inst | iss_pred_pc, 32'h0);
    rst = 1'b0;

    // Fill the queue with ADDIs and no issue
    for (int i = 0; i < 8; i++) begin
      wait_req(32'(i * 4), "fill_addr");
      respond(c_ADDI);
    end
    check_head("fill_head", 32'h0, c_ADDI, 1'b0, 32'h4);
    expect_idle(10, "full_no_req");

    // Redirect coincident with a pop
    redirect = 1'b1; redirect_pc = 32'h10; iss_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0; iss_ready = 1'b1;
    check("flush_valid", {31'h0, iss_valid}, 32'h0);
    check("flush_pc", iss_pc, 32'h0);

    // Predictor training and lookup through a short loop
    for (int v = 0; v < 10; v++) begin
      wait_req(vecs[v].addr, $sformatf("v%0d_addr", v));
      for (int u = 0; u < vecs[v].n_upd; u++) begin
        bp_upd_valid = 1'b1; bp_upd_pc = 32'h10; bp_upd_taken = vecs[v].upd_taken;
        @(negedge clk);
      end
      bp_upd_valid = 1'b0;
      respond(vecs[v].inst);
      check_head($sformatf("v%0d", v), vecs[v].addr, vecs[v].inst,
                 vecs[v].exp_taken, vecs[v].exp_pred_pc);
    end

    // JALR stalls fetch until the target resolves
    wait_req(32'h34, "jalr_addr");
    respond(c_JALR);
    check_head("jalr", 32'h34, c_JALR, 1'b0, 32'h38);
    expect_idle(8, "jalr_stall");
    jalr_done = 1'b1; jalr_target = 32'h100;
    @(negedge clk);
    jalr_done = 1'b0;
    iss_ready = 1'b0;
    wait_req(32'h100, "jalr_target");

    // Three queued, redirect in S_WAIT, late response dropped
    respond(c_ADDI);
    wait_req(32'h104, "q_addr1");
    respond(c_ADDI);
    wait_req(32'h108, "q_addr2");
    respond(c_ADDI);
    wait_req(32'h10C, "q_addr3");
    check("q_head", iss_pc, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h8;
    @(negedge clk);
    redirect = 1'b0;
    check("redir_valid", {31'h0, iss_valid}, 32'h0);
    respond(c_ADDI);
    check("drop_valid", {31'h0, iss_valid}, 32'h0);
    wait_req(32'h8, "redir_addr");

    // JAL with negative offsets, including wrap below zero
    respond(c_JAL_M8);
    check_head("jal8", 32'h8, c_JAL_M8, 1'b1, 32'h0);
    wait_req(32'h0, "jal8_next");
    respond(c_JAL_M16);
    wait_req(32'hFFFFFFF0, "jal_wrap");

    // Freeze for five cycles while issue and training try to act
    rdy = 1'b0; iss_ready = 1'b1;
    bp_upd_valid = 1'b1; bp_upd_pc = 32'h10; bp_upd_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("frz_req", {31'h0, ic_req_valid}, 32'h0);
      check("frz_head", {iss_valid, iss_pc[30:0]}, {1'b1, 31'h8});
    end
    rdy = 1'b1; iss_ready = 1'b0; bp_upd_valid = 1'b0;
    #1;
    check("unfrz_req", {ic_req_valid, ic_req_addr[30:0]}, {1'b1, 31'h7FFFFFF0});
    respond(c_ADDI);
    wait_req(32'hFFFFFFF4, "pc_wrap");

    // Redirect while a response and a pop land in the same cycle
    redirect = 1'b1; redirect_pc = 32'h10; iss_ready = 1'b1;
    ic_resp_valid = 1'b1; ic_resp_inst = c_ADDI;
    @(negedge clk);
    redirect = 1'b0; iss_ready = 1'b0; ic_resp_valid = 1'b0;
    check("redir_resp_valid", {31'h0, iss_valid}, 32'h0);
    wait_req(32'h10, "final_addr");
    respond(c_BEQ20);
    check_head("final", 32'h10, c_BEQ20, 1'b1, 32'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
